// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock FIFO with fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags and first-word-fall-through or registered read.
module fifo_lvl #(
    parameter int DATA_SZ    = 8,
    parameter int ADDR_SZ    = 4,
    parameter int AFULL_LVL  = (1 << ADDR_SZ) - 2,
    parameter int AEMPTY_LVL = 1,
    parameter int FWFT       = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_wr,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_full,
    output logic               o_afull,
    input  logic               i_rd,
    output logic [DATA_SZ-1:0] o_data,
    output logic               o_empty,
    output logic               o_aempty,
    output logic [ADDR_SZ:0]   o_count,
    output logic               o_ovf,
    output logic               o_udf
);
    localparam int DEPTH = 1 << ADDR_SZ;
    localparam logic [ADDR_SZ:0] CNT_FULL = (ADDR_SZ+1)'(DEPTH);
    logic [DATA_SZ-1:0] ram [DEPTH];
    logic [ADDR_SZ:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic               ovf_q, ovf_d, udf_q, udf_d;
    logic               rd_ok, wr_ok, wr_en;
    logic [DATA_SZ-1:0] head;
    // The extra wrap bit lets the pointer difference span 0..DEPTH, so it is the fill level.
    assign count = wr_ptr_q - rd_ptr_q;
    assign rd_ok = i_rd && count != '0;
    assign wr_ok = i_wr && (count != CNT_FULL || rd_ok);
    assign wr_en = wr_ok && !i_clr && !i_rst;
    assign head  = ram[rd_ptr_q[ADDR_SZ-1:0]];
    always_comb begin
        wr_ptr_d = i_clr ? '0 : wr_ptr_q + (ADDR_SZ+1)'(wr_ok);
        rd_ptr_d = i_clr ? '0 : rd_ptr_q + (ADDR_SZ+1)'(rd_ok);
        ovf_d    = !i_clr && (ovf_q || (i_wr && !wr_ok));
        udf_d    = !i_clr && (udf_q || (i_rd && !rd_ok));
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (wr_en) ram[wr_ptr_q[ADDR_SZ-1:0]] <= i_data;
    end
    if (FWFT != 0) begin : g_fwft
        assign o_data = head;
    end else begin : g_reg
        logic [DATA_SZ-1:0] data_q, data_d;
        assign data_d = (rd_ok && !i_clr) ? head : data_q;
        always_ff @(posedge i_clk) begin
            if (i_rst) data_q <= '0;
            else       data_q <= data_d;
        end
        assign o_data = data_q;
    end
    assign o_count  = count;
    assign o_full   = count == CNT_FULL;
    assign o_empty  = count == '0;
    assign o_afull  = int'(count) >= AFULL_LVL;
    assign o_aempty = int'(count) <= AEMPTY_LVL;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;
endmodule
